keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//   Parametrised matrix keypad scanner, the successor to the fixed 4x4 hex keypad decoder.
//   - Drives one-hot columns and samples synchronised rows.
//   - Debounces both press and release.
//   - Rejects multi-key (ghost) readings.
//   - Queues press/release events in a FIFO with a valid/ready handshake.
//   - Emits the raw key index; symbol mapping (hex digits, A-D, *, #) is done downstream.
// PARAMETERS
//   N_ROWS      4  number of row inputs (>=2)
//   N_COLS      4  number of column outputs (>=2)
//   SCAN_DIV    1000  clk cycles per scan tick (>=4; covers the 2-flop sync delay)
//   DEBOUNCE_N  4  consecutive ticks needed to accept a press or a release (>=1)
//   FIFO_DEPTH  4  event FIFO entries (power of 2, >=2)
//   REL_EVT     1  1: queue release events; 0: queue press events only
//   CW = $clog2(N_ROWS*N_COLS) (localparam)
// PORTS
//   clk        in   1         clock
//   rst        in   1         reset, asynchronous, active-high
//   row_i      in   N_ROWS    raw row lines, active-high, asynchronous
//   col_o      out  N_COLS    column drive, active-high
//   key_code   out  CW        head-of-FIFO key index = row*N_COLS + col
//   key_press  out  1         head-of-FIFO event type: 1=press, 0=release
//   key_valid  out  1         FIFO non-empty
//   key_ready  in   1         consumer accepts head when key_valid & key_ready
//   fifo_cnt   out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//   overflow   out  1         sticky: an event was dropped
//   clr_ovf    in   1         synchronous clear of overflow
//   multi_key  out  1         1-cycle pulse: ghost/multi-key reading rejected
// BEHAVIOUR
//   Reset values
//   - state=IDLE, col_o all ones, FIFO empty, key_valid=0, fifo_cnt=0.
//   - overflow=0, multi_key=0; tick counter, sync flops, col idx and debounce count all 0.
//   - key_code/key_press = 0 while the FIFO is empty.
//   Inputs and timing
//   - row_i passes a 2-flop synchroniser -> row_s.
//   - tick = 1-cycle pulse every SCAN_DIV clks, free-running from reset.
//   - All FSM decisions are taken only on tick, using row_s.
//   FSM (col_o is a Moore output of state/idx)
//   - IDLE: col_o=all ones.
//     - tick & row_s!=0 -> SCAN, idx=0.
//   - SCAN: col_o=1<<idx. On tick:
//     - row_s==0: if idx==N_COLS-1 -> IDLE, else idx++.
//     - row_s one-hot: latch cand=row_s, dcnt=1 -> DEBNC (if DEBOUNCE_N==1, go directly to the DEBNC accept action).
//     - >1 bit set: pulse multi_key -> WREL (no event queued).
//   - DEBNC: col held. On tick:
//     - row_s==cand: dcnt++; at DEBOUNCE_N push {1,code} and go to HELD with dcnt=0.
//     - otherwise -> IDLE (bounce, no event).
//   - HELD: col held. On tick:
//     - row_s==0: dcnt++; at DEBOUNCE_N push {0,code} if REL_EVT, then -> IDLE.
//     - row_s!=0: dcnt=0. Extra bits set: pulse multi_key and stay in HELD.
//   - WREL: col_o=all ones. On tick:
//     - row_s==0 for DEBOUNCE_N consecutive ticks -> IDLE.
//   Event FIFO
//   - Pop on key_valid & key_ready; head is valid combinationally from storage.
//   - Push when full with no pop: event dropped and overflow<=1.
//   - Push+pop in the same cycle: both happen, count unchanged (including when full).
//   - Push+pop when empty: the pushed event becomes the head next cycle (no bypass).
//   - Pointers wrap modulo FIFO_DEPTH.
//   - clr_ovf clears overflow; a simultaneous overflow event wins (overflow stays 1).
//   Latency
//   - Press event visible on key_valid at most (N_COLS+DEBOUNCE_N+1)*SCAN_DIV+3 clks after row_i becomes stable.
//   Reset mid-operation
//   - Everything returns to reset values immediately; no release event is queued for a key held at reset.
// TESTING (N_ROWS=N_COLS=4, SCAN_DIV=4, DEBOUNCE_N=2, FIFO_DEPTH=4, REL_EVT=1)
//   1. Hold row_i=0010 while col_o[2] is driven (model the matrix), then release.
//      -> key_code=6, key_press=1; then key_code=6, key_press=0. Exactly 2 events.
//   2. Row pulse that lasts only 1 tick.
//      -> no event, fifo_cnt stays 0, FSM back in IDLE.
//   3. Rows 0 and 3 both asserted on col 1.
//      -> multi_key pulses once, no event until all rows are 0.
//   4. key_ready=0, 3 press/release cycles.
//      -> fifo_cnt=4, overflow=1.
//      -> drain returns codes/types of the first 4 events in order.
//      -> clr_ovf clears overflow.
//   5. FIFO full and key_ready=1 on the same cycle as a push.
//      -> fifo_cnt stays 4, overflow stays 0, order preserved.
//   6. Assert rst while in HELD.
//      -> col_o=1111, key_valid=0 next edge.
//      -> after release, no release event is produced.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-hot column drive, synchronised and debounced row sampling,
// ghost-key rejection and a press/release event FIFO with a valid/ready consumer port.
module keypad_scan_fifo #(
   parameter int N_ROWS     = 4,
   parameter int N_COLS     = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE_N = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int REL_EVT    = 1,
   localparam int CW        = $clog2(N_ROWS*N_COLS),
   localparam int CNTW      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_ROWS-1:0] row_i,
   output logic [N_COLS-1:0] col_o,
   output logic [CW-1:0]     key_code,
   output logic              key_press,
   output logic              key_valid,
   input  logic              key_ready,
   output logic [CNTW-1:0]   fifo_cnt,
   output logic              overflow,
   input  logic              clr_ovf,
   output logic              multi_key
);

   localparam int IW = $clog2(N_COLS);
   localparam int RW = $clog2(N_ROWS);
   localparam int DW = $clog2(DEBOUNCE_N+1);
   localparam int TW = $clog2(SCAN_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SCAN, DEBNC, HELD, WREL} state_t;

   state_t            r_state;
   logic [N_ROWS-1:0] r_rowMeta;
   logic [N_ROWS-1:0] r_rowSync;
   logic [TW-1:0]     r_tickCnt;
   logic [N_COLS-1:0] r_col;
   logic [IW-1:0]     r_idx;
   logic [N_ROWS-1:0] r_cand;
   logic [DW-1:0]     r_dcnt;
   logic [CW-1:0]     r_code;
   logic              r_multi;
   logic [CW:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [CNTW-1:0]   r_cnt;
   logic              r_ovf;

   logic              w_tick;
   logic              w_rowZero;
   logic              w_rowOneHot;
   logic [RW-1:0]     w_rowIdx;
   logic [CW-1:0]     w_scanCode;
   logic [DW-1:0]     w_dcntInc;
   logic              w_dcntDone;
   logic              w_push;
   logic              w_pushPress;
   logic [CW-1:0]     w_pushCode;
   logic              w_pop;
   logic              w_full;
   logic              w_wrEn;
   logic [CW:0]       w_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rowMeta <= '0;
         r_rowSync <= '0;
      end else begin
         r_rowMeta <= row_i;
         r_rowSync <= r_rowMeta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_tickCnt <= '0;
      else if (w_tick)
         r_tickCnt <= '0;
      else
         r_tickCnt <= r_tickCnt + TW'(1);
   end

   assign w_tick      = (r_tickCnt == TW'(SCAN_DIV-1));
   assign w_rowZero   = (r_rowSync == '0);
   assign w_rowOneHot = !w_rowZero && ((r_rowSync & (r_rowSync - N_ROWS'(1))) == '0);
   assign w_scanCode  = CW'(w_rowIdx) * CW'(N_COLS) + CW'(r_idx);
   assign w_dcntInc   = r_dcnt + DW'(1);
   assign w_dcntDone  = (w_dcntInc == DW'(DEBOUNCE_N));

   always_comb begin
      w_rowIdx = '0;
      for (int r = 0; r < N_ROWS; r++)
         if (r_rowSync[r]) w_rowIdx = RW'(r);
   end

   // Events go straight into the FIFO on the tick that accepts them.
   always_comb begin
      w_push      = 1'b0;
      w_pushPress = 1'b1;
      w_pushCode  = r_code;
      if (w_tick) begin
         case (r_state)
            SCAN:
               if (w_rowOneHot && DEBOUNCE_N == 1) begin
                  w_push     = 1'b1;
                  w_pushCode = w_scanCode;
               end
            DEBNC:
               if (r_rowSync == r_cand && w_dcntDone) w_push = 1'b1;
            HELD:
               if (w_rowZero && w_dcntDone && REL_EVT != 0) begin
                  w_push      = 1'b1;
                  w_pushPress = 1'b0;
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= '1;
         r_idx   <= '0;
         r_cand  <= '0;
         r_dcnt  <= '0;
         r_code  <= '0;
         r_multi <= 1'b0;
      end else begin
         r_multi <= 1'b0;
         if (w_tick) begin
            case (r_state)
               IDLE:
                  if (!w_rowZero) begin
                     r_state <= SCAN;
                     r_idx   <= '0;
                     r_col   <= N_COLS'(1);
                  end
               SCAN:
                  if (w_rowZero) begin
                     if (r_idx == IW'(N_COLS-1)) begin
                        r_state <= IDLE;
                        r_col   <= '1;
                     end else begin
                        r_idx <= r_idx + IW'(1);
                        r_col <= r_col << 1;
                     end
                  end else if (w_rowOneHot) begin
                     r_cand <= r_rowSync;
                     r_code <= w_scanCode;
                     if (DEBOUNCE_N == 1) begin
                        r_state <= HELD;
                        r_dcnt  <= '0;
                     end else begin
                        r_state <= DEBNC;
                        r_dcnt  <= DW'(1);
                     end
                  end else begin
                     r_multi <= 1'b1;
                     r_state <= WREL;
                     r_col   <= '1;
                     r_dcnt  <= '0;
                  end
               DEBNC:
                  if (r_rowSync == r_cand) begin
                     if (w_dcntDone) begin
                        r_state <= HELD;
                        r_dcnt  <= '0;
                     end else begin
                        r_dcnt <= w_dcntInc;
                     end
                  end else begin
                     r_state <= IDLE;
                     r_col   <= '1;
                  end
               HELD:
                  if (w_rowZero) begin
                     if (w_dcntDone) begin
                        r_state <= IDLE;
                        r_col   <= '1;
                        r_dcnt  <= '0;
                     end else begin
                        r_dcnt <= w_dcntInc;
                     end
                  end else begin
                     r_dcnt <= '0;
                     if ((r_rowSync & ~r_cand) != '0) r_multi <= 1'b1;
                  end
               WREL:
                  if (w_rowZero) begin
                     if (w_dcntDone) begin
                        r_state <= IDLE;
                        r_dcnt  <= '0;
                     end else begin
                        r_dcnt <= w_dcntInc;
                     end
                  end else begin
                     r_dcnt <= '0;
                  end
               default: begin
                  r_state <= IDLE;
                  r_col   <= '1;
               end
            endcase
         end
      end
   end

   assign w_pop  = (r_cnt != '0) && key_ready;
   assign w_full = (r_cnt == CNTW'(FIFO_DEPTH));
   assign w_wrEn = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wrEn) r_mem[r_wrPtr] <= {w_pushPress, w_pushCode};
   end

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wrEn) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_wrEn, w_pop})
            2'b10:   r_cnt <= r_cnt + CNTW'(1);
            2'b01:   r_cnt <= r_cnt - CNTW'(1);
            default: ;
         endcase
         if (w_push && w_full && !w_pop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

   assign key_valid = (r_cnt != '0);
   assign w_head    = key_valid ? r_mem[r_rdPtr] : '0;
   assign key_press = w_head[CW];
   assign key_code  = w_head[CW-1:0];
   assign fifo_cnt  = r_cnt;
   assign overflow  = r_ovf;
   assign multi_key = r_multi;
   assign col_o     = r_col;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a modelled 4x4 key matrix drives the rows from col_o,
// each scenario task checks its own results against hand-computed values.
module tb_keypad_scan_fifo;

   localparam int NR = 4;
   localparam int NC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_i;
   logic [3:0] col_o;
   logic [3:0] key_code;
   logic       key_press;
   logic       key_valid;
   logic       key_ready;
   logic [2:0] fifo_cnt;
   logic       overflow;
   logic       clr_ovf;
   logic       multi_key;

   logic [15:0] keyMask;
   logic        useRaw;
   logic [3:0]  rawRow;
   int          testsRun = 0;
   int          testsFailed = 0;
   int          multiCnt = 0;

   keypad_scan_fifo #(
      .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .DEBOUNCE_N(2), .FIFO_DEPTH(4), .REL_EVT(1)
   ) dut (
      .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o), .key_code(key_code),
      .key_press(key_press), .key_valid(key_valid), .key_ready(key_ready),
      .fifo_cnt(fifo_cnt), .overflow(overflow), .clr_ovf(clr_ovf), .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key at (r,c) connects column c to row r.
   always_comb begin
      row_i = '0;
      if (useRaw) begin
         row_i = rawRow;
      end else begin
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
               if (keyMask[r*NC+c] && col_o[c]) row_i[r] = 1'b1;
      end
   end

   always @(posedge clk) if (multi_key) multiCnt <= multiCnt + 1;

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitValid(input int maxCyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCyc && !ok; i++) begin
         @(negedge clk);
         if (key_valid) ok = 1'b1;
      end
   endtask

   task automatic waitCol(input logic [3:0] target, input int maxCyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCyc && !ok; i++) begin
         @(negedge clk);
         if (col_o == target) ok = 1'b1;
      end
   endtask

   task automatic popOne();
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   task automatic pressRelease(input int code);
      keyMask = '0;
      keyMask[code] = 1'b1;
      waitCycles(60);
      keyMask = '0;
      waitCycles(60);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      waitCycles(2);
      testsRun++;
      if (col_o !== 4'hF) begin testsFailed++; $display("[TB] FAIL reset_col got %h want f", col_o); end
      testsRun++;
      if (key_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
         testsFailed++; $display("[TB] FAIL reset_fifo valid=%b cnt=%0d want 0/0", key_valid, fifo_cnt);
      end
      testsRun++;
      if (overflow !== 1'b0 || multi_key !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_flags ovf=%b multi=%b want 0/0", overflow, multi_key);
      end
      testsRun++;
      if (key_code !== 4'd0 || key_press !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_head code=%0d press=%b want 0/0", key_code, key_press);
      end
      rst = 1'b0;
      waitCycles(2);
   endtask

   task automatic test_press_release();
      bit ok;
      keyMask = 16'h0040;
      waitValid(100, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL t1_press_timeout valid=%b want 1", key_valid); end
      testsRun++;
      if (key_code !== 4'd6 || key_press !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL t1_press code=%0d press=%b want 6/1", key_code, key_press);
      end
      waitCycles(40);
      testsRun++;
      if (fifo_cnt !== 3'd1) begin testsFailed++; $display("[TB] FAIL t1_single_press cnt=%0d want 1", fifo_cnt); end
      popOne();
      keyMask = '0;
      waitValid(100, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL t1_release_timeout valid=%b want 1", key_valid); end
      testsRun++;
      if (key_code !== 4'd6 || key_press !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL t1_release code=%0d press=%b want 6/0", key_code, key_press);
      end
      popOne();
      waitCycles(60);
      testsRun++;
      if (fifo_cnt !== 3'd0 || col_o !== 4'hF) begin
         testsFailed++; $display("[TB] FAIL t1_two_events cnt=%0d col=%h want 0/f", fifo_cnt, col_o);
      end
   endtask

   task automatic test_bounce();
      useRaw = 1'b1;
      rawRow = 4'b0010;
      waitCycles(4);
      rawRow = 4'b0000;
      waitCycles(60);
      useRaw = 1'b0;
      testsRun++;
      if (fifo_cnt !== 3'd0 || key_valid !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL t2_bounce cnt=%0d valid=%b want 0/0", fifo_cnt, key_valid);
      end
      testsRun++;
      if (col_o !== 4'hF) begin testsFailed++; $display("[TB] FAIL t2_idle col=%h want f", col_o); end
   endtask

   task automatic test_multi_key();
      int base;
      base = multiCnt;
      keyMask = 16'h2002;
      waitCycles(60);
      testsRun++;
      if (multiCnt - base != 1) begin
         testsFailed++; $display("[TB] FAIL t3_multi_pulse count=%0d want 1", multiCnt - base);
      end
      testsRun++;
      if (fifo_cnt !== 3'd0 || col_o !== 4'hF) begin
         testsFailed++; $display("[TB] FAIL t3_held cnt=%0d col=%h want 0/f", fifo_cnt, col_o);
      end
      keyMask = '0;
      waitCycles(60);
      testsRun++;
      if (fifo_cnt !== 3'd0 || multiCnt - base != 1) begin
         testsFailed++; $display("[TB] FAIL t3_after_release cnt=%0d pulses=%0d want 0/1", fifo_cnt, multiCnt - base);
      end
   endtask

   task automatic test_overflow();
      int expCode[4] = '{6, 6, 9, 9};
      bit expPress[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      key_ready = 1'b0;
      pressRelease(6);
      pressRelease(9);
      pressRelease(3);
      testsRun++;
      if (fifo_cnt !== 3'd4 || overflow !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL t4_full cnt=%0d ovf=%b want 4/1", fifo_cnt, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (key_valid !== 1'b1 || key_code !== 4'(expCode[i]) || key_press !== expPress[i]) begin
            testsFailed++;
            $display("[TB] FAIL t4_drain%0d valid=%b code=%0d press=%b want 1/%0d/%b",
                     i, key_valid, key_code, key_press, expCode[i], expPress[i]);
         end
         popOne();
      end
      testsRun++;
      if (fifo_cnt !== 3'd0 || overflow !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL t4_sticky cnt=%0d ovf=%b want 0/1", fifo_cnt, overflow);
      end
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      testsRun++;
      if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL t4_clr_ovf ovf=%b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int expCode[4] = '{5, 10, 10, 15};
      bit expPress[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      key_ready = 1'b0;
      pressRelease(5);
      pressRelease(10);
      testsRun++;
      if (fifo_cnt !== 3'd4 || overflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL t5_prefill cnt=%0d ovf=%b want 4/0", fifo_cnt, overflow);
      end
      // Column 3 appears on a tick; the press is accepted two ticks (8 clocks) later.
      keyMask = 16'h8000;
      waitCol(4'b1000, 100, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL t5_col3_timeout col=%h want 8", col_o); end
      waitCycles(7);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      testsRun++;
      if (fifo_cnt !== 3'd4 || overflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL t5_push_pop cnt=%0d ovf=%b want 4/0", fifo_cnt, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (key_valid !== 1'b1 || key_code !== 4'(expCode[i]) || key_press !== expPress[i]) begin
            testsFailed++;
            $display("[TB] FAIL t5_order%0d valid=%b code=%0d press=%b want 1/%0d/%b",
                     i, key_valid, key_code, key_press, expCode[i], expPress[i]);
         end
         popOne();
      end
      keyMask = '0;
      waitValid(100, ok);
      testsRun++;
      if (!ok || key_code !== 4'd15 || key_press !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL t5_release15 valid=%b code=%0d press=%b want 1/15/0", key_valid, key_code, key_press);
      end
      popOne();
   endtask

   task automatic test_reset_held();
      bit ok;
      keyMask = 16'h0040;
      waitValid(100, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL t6_press_timeout valid=%b want 1", key_valid); end
      waitCycles(3);
      rst = 1'b1;
      #1;
      testsRun++;
      if (col_o !== 4'hF || key_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
         testsFailed++; $display("[TB] FAIL t6_async_reset col=%h valid=%b cnt=%0d want f/0/0", col_o, key_valid, fifo_cnt);
      end
      keyMask = '0;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(60);
      testsRun++;
      if (fifo_cnt !== 3'd0 || key_valid !== 1'b0 || col_o !== 4'hF) begin
         testsFailed++; $display("[TB] FAIL t6_no_release cnt=%0d valid=%b col=%h want 0/0/f", fifo_cnt, key_valid, col_o);
      end
   endtask

   initial begin
      rst       = 1'b1;
      keyMask   = '0;
      useRaw    = 1'b0;
      rawRow    = '0;
      key_ready = 1'b0;
      clr_ovf   = 1'b0;
      test_reset();
      test_press_release();
      test_bounce();
      test_multi_key();
      test_overflow();
      test_back_to_back();
      test_reset_held();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
